// File: rtl/fsm_tbl_pkg.sv
// fsm_tbl_pkg: shared helpers for the table-driven Mealy FSM
package fsm_tbl_pkg;
  function automatic logic [63:0] defaultEntry(input int row, input int outW);
    return 64'(row) << outW;
  endfunction
  function automatic logic [63:0] satInc(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = (64'(1) << w) - 64'(1);
    return (v >= top) ? top : v + 64'(1);
  endfunction
endpackage

// File: rtl/fsm_table_ram.sv
// fsm_table_ram: transition/output register array, sync write, hold-all reset, comb read
module fsm_table_ram import fsm_tbl_pkg::*; #(
  parameter int N_STATES = 8,
  parameter int IN_W = 1,
  parameter int OUT_W = 1,
  parameter int SW = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [SW-1:0]       wState,
  input  logic [IN_W-1:0]     wIn,
  input  logic [SW+OUT_W-1:0] wData,
  input  logic [SW-1:0]       rState,
  input  logic [IN_W-1:0]     rIn,
  output logic [SW+OUT_W-1:0] rData
);
  localparam int EW = SW + OUT_W;
  logic [EW-1:0] mem [N_STATES][2**IN_W];
  assign rData = mem[rState][rIn];
  always_ff @(posedge clk)
    if (reset) begin
      for (int r = 0; r < N_STATES; r++)
        for (int c = 0; c < 2**IN_W; c++)
          mem[r][c] <= EW'(defaultEntry(r, OUT_W));
    end else if (we) begin
      mem[wState][wIn] <= wData;
    end
endmodule

// File: rtl/table_mealy_fsm.sv
// table_mealy_fsm: runtime-loadable Mealy FSM with accept pulse, saturating counter, cfg error flag
module table_mealy_fsm import fsm_tbl_pkg::*; #(
  parameter int N_STATES = 8,
  parameter int IN_W = 1,
  parameter int OUT_W = 1,
  parameter int RESET_STATE = 0,
  parameter int ACCEPT_STATE = 7,
  parameter int CNT_W = 16,
  localparam int SW = $clog2(N_STATES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IN_W-1:0]  x,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_state,
  input  logic [IN_W-1:0]  cfg_in,
  input  logic [SW-1:0]    cfg_next,
  input  logic [OUT_W-1:0] cfg_out,
  output logic [OUT_W-1:0] y,
  output logic [SW-1:0]    currentState,
  output logic [SW-1:0]    nextState,
  output logic             accept,
  output logic             cfg_err,
  output logic [CNT_W-1:0] trans_cnt
);
  localparam logic [SW:0] NS = (SW+1)'(N_STATES);
  localparam logic [SW-1:0] RST = SW'(RESET_STATE);
  localparam logic [SW-1:0] ACC = SW'(ACCEPT_STATE);
  logic [SW+OUT_W-1:0] entry;
  logic legal;
  // out-of-range rows or targets are only reachable when N_STATES is not a power of 2
  assign legal = ({1'b0, cfg_state} < NS) && ({1'b0, cfg_next} < NS);
  assign y = entry[OUT_W-1:0];
  assign nextState = en ? entry[SW+OUT_W-1:OUT_W] : currentState;
  fsm_table_ram #(.N_STATES(N_STATES), .IN_W(IN_W), .OUT_W(OUT_W), .SW(SW)) u_ram (
    .clk(clk),
    .reset(reset),
    .we(cfg_we && legal),
    .wState(cfg_state),
    .wIn(cfg_in),
    .wData({cfg_next, cfg_out}),
    .rState(currentState),
    .rIn(x),
    .rData(entry)
  );
  always_ff @(posedge clk)
    if (reset) begin
      currentState <= RST;
      accept <= 1'b0;
      cfg_err <= 1'b0;
      trans_cnt <= '0;
    end else begin
      currentState <= nextState;
      accept <= en && nextState == ACC && currentState != ACC;
      cfg_err <= cfg_err || (cfg_we && !legal);
      trans_cnt <= (nextState != currentState) ? CNT_W'(satInc(64'(trans_cnt), CNT_W)) : trans_cnt;
    end
endmodule

// File: tb/tb_table_mealy_fsm.sv
// tb_table_mealy_fsm: directed checks of table_mealy_fsm (default, 6-state and 2-bit-counter builds)
module tb_table_mealy_fsm;
  logic clk = 0, reset = 1;
  logic en = 0, cfgWe = 0;
  logic [0:0] x = 0, cfgIn = 0, cfgOut = 0;
  logic [2:0] cfgState = 0, cfgNext = 0;
  logic [0:0] y, yC, y6;
  logic [2:0] curState, nxtState, curC, nxtC, cur6, nxt6;
  logic accept, cfgErr, accC, errC, acc6, err6;
  logic [15:0] transCnt, cnt6;
  logic [1:0] cntC;
  logic en6 = 0, we6 = 0;
  logic [0:0] x6 = 0, in6 = 0, out6 = 0;
  logic [2:0] st6 = 0, nx6 = 0;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  table_mealy_fsm dut (.clk(clk), .reset(reset), .en(en), .x(x), .cfg_we(cfgWe), .cfg_state(cfgState),
    .cfg_in(cfgIn), .cfg_next(cfgNext), .cfg_out(cfgOut), .y(y), .currentState(curState),
    .nextState(nxtState), .accept(accept), .cfg_err(cfgErr), .trans_cnt(transCnt));
  table_mealy_fsm #(.CNT_W(2)) dutC (.clk(clk), .reset(reset), .en(en), .x(x), .cfg_we(cfgWe),
    .cfg_state(cfgState), .cfg_in(cfgIn), .cfg_next(cfgNext), .cfg_out(cfgOut), .y(yC),
    .currentState(curC), .nextState(nxtC), .accept(accC), .cfg_err(errC), .trans_cnt(cntC));
  table_mealy_fsm #(.N_STATES(6), .ACCEPT_STATE(5)) dut6 (.clk(clk), .reset(reset), .en(en6), .x(x6),
    .cfg_we(we6), .cfg_state(st6), .cfg_in(in6), .cfg_next(nx6), .cfg_out(out6), .y(y6),
    .currentState(cur6), .nextState(nxt6), .accept(acc6), .cfg_err(err6), .trans_cnt(cnt6));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int i, input int n, input int o);
    cfgWe = 1; cfgState = 3'(s); cfgIn = 1'(i); cfgNext = 3'(n); cfgOut = 1'(o);
    tick();
    cfgWe = 0;
  endtask

  task automatic wr6(input int s, input int n, input int o);
    we6 = 1; st6 = 3'(s); in6 = 0; nx6 = 3'(n); out6 = 1'(o);
    tick();
    we6 = 0;
  endtask

  task automatic peek6(input string tag, input int n, input int o);
    en6 = 1;
    #1;
    check({tag, "_next"}, 32'(nxt6), n);
    check({tag, "_y"}, 32'(y6), o);
    en6 = 0;
  endtask

  task automatic step(input int xv, input int n, input int o);
    en = 1; x = 1'(xv);
    #1;
    check("pre_y", 32'(y), o);
    check("pre_next", 32'(nxtState), n);
    tick();
    en = 0;
    check("state", 32'(curState), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_state", 32'(curState), 0);
    check("rst_accept", 32'(accept), 0);
    check("rst_err", 32'(cfgErr), 0);
    check("rst_cnt", 32'(transCnt), 0);
    check("rst_y", 32'(y), 0);
    check("rst_err6", 32'(err6), 0);
    reset = 0;
    en = 1; x = 1;
    #1;
    check("rst_hold_next", 32'(nxtState), 0);
    check("rst_hold_y", 32'(y), 0);
    en = 0;

    wr6(6, 1, 1);
    check("err6_row", 32'(err6), 1);
    wr6(0, 7, 1);
    check("err6_sticky", 32'(err6), 1);
    peek6("err6_drop", 0, 0);
    wr6(0, 3, 1);
    peek6("err6_legal", 3, 1);
    check("err6_still", 32'(err6), 1);
    check("err6_state", 32'(cur6), 0);

    wr(0, 0, 5, 0); wr(0, 1, 1, 0); wr(1, 0, 3, 0); wr(1, 1, 2, 0);
    wr(2, 0, 5, 0); wr(2, 1, 4, 0); wr(3, 0, 6, 1); wr(3, 1, 0, 0);
    wr(4, 0, 3, 0); wr(4, 1, 2, 0); wr(5, 0, 5, 1); wr(5, 1, 1, 1);
    wr(6, 0, 6, 0); wr(6, 1, 7, 1); wr(7, 0, 6, 1); wr(7, 1, 0, 0);
    check("load_state", 32'(curState), 0);
    check("load_err", 32'(cfgErr), 0);

    step(1, 1, 0); check("cnt1", 32'(transCnt), 1); check("cntC1", 32'(cntC), 1); check("acc1", 32'(accept), 0);
    step(1, 2, 0); check("cnt2", 32'(transCnt), 2); check("cntC2", 32'(cntC), 2);
    step(1, 4, 0); check("cnt3", 32'(transCnt), 3); check("cntC3", 32'(cntC), 3);
    step(0, 3, 0); check("cnt4", 32'(transCnt), 4); check("cntC4", 32'(cntC), 3);
    check("acc4", 32'(accept), 0);

    en = 1; x = 0;
    cfgWe = 1; cfgState = 3; cfgIn = 0; cfgNext = 1; cfgOut = 0;
    #1;
    check("same_y", 32'(y), 1);
    check("same_next", 32'(nxtState), 6);
    tick();
    cfgWe = 0; en = 0;
    check("same_state", 32'(curState), 6);
    check("cnt5", 32'(transCnt), 5);
    check("cntC5", 32'(cntC), 3);

    step(1, 7, 1);
    check("acc_pulse", 32'(accept), 1);
    check("cnt6", 32'(transCnt), 6);

    for (int i = 0; i < 5; i++) begin
      x = 1'(i % 2);
      #1;
      check("hold_next", 32'(nxtState), 7);
      check("hold_y", 32'(y), (i % 2 == 0) ? 1 : 0);
      tick();
      check("hold_state", 32'(curState), 7);
      check("hold_cnt", 32'(transCnt), 6);
      check("hold_acc", 32'(accept), 0);
    end

    wr(7, 0, 7, 1);
    step(0, 7, 1); check("self_acc", 32'(accept), 0); check("self_cnt", 32'(transCnt), 6);
    step(1, 0, 0); check("cnt7", 32'(transCnt), 7); check("acc7", 32'(accept), 0);
    step(1, 1, 0);
    step(0, 3, 0);
    step(0, 1, 0); check("revisit_cnt", 32'(transCnt), 10);
    wr(1, 1, 6, 0);
    step(1, 6, 0); check("cnt11", 32'(transCnt), 11);

    reset = 1; en = 1; x = 1;
    cfgWe = 1; cfgState = 0; cfgIn = 0; cfgNext = 2; cfgOut = 1;
    tick();
    reset = 0; cfgWe = 0;
    check("mrst_state", 32'(curState), 0);
    check("mrst_accept", 32'(accept), 0);
    check("mrst_err", 32'(cfgErr), 0);
    check("mrst_cnt", 32'(transCnt), 0);
    check("mrst_cntC", 32'(cntC), 0);
    for (int i = 0; i < 2; i++) begin
      x = 1'(i);
      #1;
      check("mrst_next", 32'(nxtState), 0);
      check("mrst_y", 32'(y), 0);
    end
    en = 0;
    tick();
    check("mrst_stay", 32'(curState), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
